// File: rtl/pattern_detector_moore.sv
// Moore serial pattern detector: dout is high while the FSM sits in the full-match state.
// Optional PATTERN_DETECTOR_MATCH_COUNT_EN adds a saturating 16-bit match counter output.
module pattern_detector_moore #(
    parameter int                  PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0]  PATTERN = 5'b10101,
    parameter bit                  OVERLAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
    output logic [15:0] match_count,
`endif
    output logic        dout
);

    localparam int SW    = $clog2(PAT_LEN + 1);
    localparam int TBL_W = 2 * (PAT_LEN + 1) * SW;

    typedef logic [SW-1:0] state_t;

    localparam state_t S_IDLE  = state_t'(0);
    localparam state_t S_MATCH = state_t'(PAT_LEN);

    // Entry (2*k + b) holds the successor of state k on input bit b. Each entry is the
    // longest pattern prefix that is a suffix of (first k pattern bits, then b).
    function automatic logic [TBL_W-1:0] build_table();
        logic [TBL_W-1:0] tbl;
        logic [31:0]      recv;
        logic [31:0]      mask;
        logic [31:0]      prefix;
        int               base;
        int               best;
        tbl = '0;
        for (int k = 0; k <= PAT_LEN; k++) begin
            for (int b = 0; b < 2; b++) begin
                base = ((k == PAT_LEN) && !OVERLAP) ? 0 : k;
                recv = (32'(PATTERN) >> (PAT_LEN - base));
                recv = (recv << 1) | 32'(b);
                best = 0;
                for (int j = 1; j <= PAT_LEN; j++) begin
                    if (j <= base + 1) begin
                        mask   = (32'd1 << j) - 32'd1;
                        prefix = 32'(PATTERN) >> (PAT_LEN - j);
                        if ((recv & mask) == prefix) begin
                            best = j;
                        end
                    end
                end
                tbl[(2 * k + b) * SW +: SW] = SW'(best);
            end
        end
        return tbl;
    endfunction

    localparam logic [TBL_W-1:0] NEXT_TBL = build_table();

    state_t state_q, state_d;
    logic   dout_q,  dout_d;

    always_comb begin
        state_d = NEXT_TBL[(2 * int'(state_q) + int'(din)) * SW +: SW];
        dout_d  = (state_d == S_MATCH);
        if (rst) begin
            state_d = S_IDLE;
            dout_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        dout_q  <= dout_d;
    end

    assign dout = dout_q;

`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (rst) begin
            count_d = '0;
        end else if (state_d == S_MATCH && count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign match_count = count_q;
`endif

endmodule

// File: tb/tb_pattern_detector_moore.sv
// Bench for pattern_detector_moore: overlapping and non-overlapping instances share one
// bit stream; a driver queues hand-computed expectations and a monitor checks each cycle.
module tb_pattern_detector_moore;

    localparam int N_VEC = 31;
    localparam int W     = 34;

    logic        clk;
    logic        rst;
    logic        din;
    logic        dout_ov;
    logic        dout_nov;
    logic [15:0] cnt_ov;
    logic [15:0] cnt_nov;

    logic [W-1:0] exp_q[$];
    int           n_checks;
    int           n_fail;
    bit           driving_done;

    pattern_detector_moore #(.PAT_LEN(5), .PATTERN(5'b10101), .OVERLAP(1'b1)) u_ov (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
        .match_count (cnt_ov),
`endif
        .dout        (dout_ov)
    );

    pattern_detector_moore #(.PAT_LEN(5), .PATTERN(5'b10101), .OVERLAP(1'b0)) u_nov (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
        .match_count (cnt_nov),
`endif
        .dout        (dout_nov)
    );

`ifndef PATTERN_DETECTOR_MATCH_COUNT_EN
    assign cnt_ov  = '0;
    assign cnt_nov = '0;
`endif

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {rst, din, dout_ov, dout_nov} expected after the edge that samples the vector
    logic [3:0] vec_tbl [0:N_VEC-1] = '{
        4'b1100, 4'b1100, 4'b1100, 4'b0000,          // reset with din=1, release with din=0
        4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0111, // 10101 -> match on 5th bit
        4'b0000, 4'b0110,                            // overlap: 0 then 1
        4'b1000,                                     // reset
        4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0100, // 01011 never matches
        4'b1000,                                     // reset
        4'b0100, 4'b0000, 4'b0100, 4'b0000,          // partial 1010
        4'b1100,                                     // reset mid-pattern with din=1
        4'b0100,                                     // 1 -> S1
        4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0111, // full 10101
        4'b0000, 4'b0110                             // overlap again
    };
    int cnt_ov_tbl  [0:N_VEC-1] = '{0,0,0,0, 0,0,0,0,1, 1,2, 0, 0,0,0,0,0, 0, 0,0,0,0, 0, 0, 0,0,0,0,1, 1,2};
    int cnt_nov_tbl [0:N_VEC-1] = '{0,0,0,0, 0,0,0,0,1, 1,1, 0, 0,0,0,0,0, 0, 0,0,0,0, 0, 0, 0,0,0,0,1, 1,1};

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s vec%0d: got %0h expected %0h", name, idx, act, expv);
        end
    endtask

    // driver
    task automatic drive_vec(input int i);
        @(negedge clk);
        rst = vec_tbl[i][3];
        din = vec_tbl[i][2];
        exp_q.push_back({vec_tbl[i][1], vec_tbl[i][0], 16'(cnt_ov_tbl[i]), 16'(cnt_nov_tbl[i])});
    endtask

    initial begin
        rst          = 1'b1;
        din          = 1'b0;
        n_checks     = 0;
        n_fail       = 0;
        driving_done = 1'b0;
        for (int i = 0; i < N_VEC; i++) begin
            drive_vec(i);
        end
        @(negedge clk);
        rst = 1'b0;
        din = 1'b0;
        driving_done = 1'b1;
    end

    // scoreboard monitor
    initial begin
        logic [W-1:0] e;
        int idx;
        idx = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dout_ov",  idx, 16'(dout_ov),  16'(e[33]));
                check("dout_nov", idx, 16'(dout_nov), 16'(e[32]));
`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
                check("cnt_ov",   idx, cnt_ov,  e[31:16]);
                check("cnt_nov",  idx, cnt_nov, e[15:0]);
`endif
                idx++;
            end
        end
    end

    // final report
    initial begin
        int budget;
        budget = 0;
        while (!(driving_done && exp_q.size() == 0) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: %0d expectations still queued, expected 0", exp_q.size());
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_detector_moore.md
Name: pattern_detector_moore

Overview:
- Serial bit-stream sequence detector, Moore style. Samples one input bit per clock and asserts `dout` while the FSM sits in the "full pattern matched" state.
- Default pattern is 10101, with overlapping matches allowed.
- Used as a leaf block in front of framing/sync logic that needs a single-bit match flag.

Parameters:
- PAT_LEN, 5, pattern length in bits (2..16).
- PATTERN, 5'b10101, target sequence. The MSB is the first bit received; the LSB is the last.
- OVERLAP, 1, 1 = overlapping matches allowed, 0 = detection restarts from scratch after a match.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial data bit, sampled on each rising clk edge.
- dout  output  1  match flag. Moore output: a function of state only.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset:
  - `rst`=1 at a rising edge forces state S0; `dout`=0 from that edge on.
  - Reset takes priority over `din`.
  - Asserting reset mid-pattern discards all partial progress.
- States S0..S_PAT_LEN:
  - Sk means the last k sampled bits equal the first k bits of PATTERN (MSB first), with k maximal.
  - For the default pattern, S0=idle, S1="1", S2="10", S3="101", S4="1010", S5="10101".
- Transitions, from Sk with k<PAT_LEN:
  - If `din` equals pattern bit k (counting from the MSB), go to S(k+1).
  - Otherwise go to the longest Sj such that the first j pattern bits equal the suffix of the received string (KMP failure function).
  - Default pattern table:
    - S0: 1->S1, 0->S0
    - S1: 0->S2, 1->S1
    - S2: 1->S3, 0->S0
    - S3: 0->S4, 1->S1
    - S4: 1->S5, 0->S0
- Transitions from S_PAT_LEN:
  - OVERLAP=1: use the failure function of the full pattern. Default: 0->S4, 1->S1.
  - OVERLAP=0: behave as S0. Default: 1->S1, 0->S0.
- Output:
  - `dout`=1 exactly when state==S_PAT_LEN. It is driven from the state register, with no combinational path from `din`.
- Latency:
  - The rising edge that samples the final pattern bit moves the FSM to S_PAT_LEN.
  - `dout` goes high immediately after that edge and stays high for exactly one cycle, unless the next bit re-enters S_PAT_LEN. That cannot happen for patterns of length ≥2 that are not all-equal bits.
- Transition computation:
  - The table is computed at elaboration from PATTERN/PAT_LEN (function or generate); it is not hand-coded.
  - A state register of width clog2(PAT_LEN+1) is sufficient.
- `din` is treated as 0/1 only; no X handling is required.

Optional Feature:
- Macro PATTERN_DETECTOR_MATCH_COUNT_EN.
- When defined:
  - Adds output port `match_count` [15:0].
  - Increments by 1 on every rising edge that enters S_PAT_LEN.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by `rst`.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold `rst`=1 with `din`=1 for 3 cycles -> state S0, `dout`=0 on every cycle; release reset, drive `din`=0 -> `dout` remains 0.
- Basic match: after reset, drive 1,0,1,0,1 on consecutive edges -> `dout`=0 through the 4th edge, `dout`=1 for exactly the cycle after the 5th edge.
- Overlap: continue 0,1 after the first match (stream 1010101) -> `dout` low after the "0", high again after the "1". That is 2 matches in 7 bits, S5->S4->S5.
- Non-matching stream: 0,1,0,1,1 from S0 -> `dout` never asserts; states S0,S1,S2,S3,S1.
- OVERLAP=0 variant: stream 1010101 -> exactly 1 match, at bit 5; bits 6-7 end in S1 with `dout`=0.
- Reset mid-pattern: 1,0,1,0 then `rst` for 1 cycle then 1 -> `dout` stays 0 (state S1); full 10101 afterwards -> match. With the macro enabled, `match_count` increments to 1 only after the post-reset 10101.
